// File: rtl/paddle_motion_ctrl.sv
// Per-paddle position engine: joystick zone -> speed FSM -> clamped y, updated once per frame.
// Optional feature macro PADDLE_AUTO_EN adds auto_mode/target_y tracking of a target coordinate.
module paddle_motion_ctrl #(
  parameter int               POS_W        = 10,
  parameter int               JOY_W        = 10,
  parameter int               Y_INIT       = 40,
  parameter int               Y_MIN        = 10,
  parameter int               Y_MAX        = 420,
  parameter int               PADDLE_H     = 50,
  parameter logic [JOY_W-1:0] FAST_HI      = 10'h300,
  parameter logic [JOY_W-1:0] DEAD_HI      = 10'h220,
  parameter logic [JOY_W-1:0] DEAD_LO      = 10'h180,
  parameter logic [JOY_W-1:0] FAST_LO      = 10'h0F0,
  parameter int               SLOW_STEP    = 1,
  parameter int               FAST_STEP    = 3,
  parameter int               BOOST_STEP   = 6,
  parameter int               BOOST_FRAMES = 8,
  parameter int               STALE_FRAMES = 30
`ifdef PADDLE_AUTO_EN
  ,
  parameter int               AUTO_DEAD      = 2,
  parameter int               AUTO_FAST_DIST = 16
`endif
) (
  input  logic             clk50M,
  input  logic             reset,
  input  logic             endofframe,
  input  logic [JOY_W-1:0] joy_y,
  input  logic             joy_valid,
  output logic [POS_W-1:0] y,
  output logic             isMoving,
  output logic [1:0]       speed_state,
  output logic             at_top,
  output logic             at_bot,
  output logic             stale
`ifdef PADDLE_AUTO_EN
  ,
  input  logic             auto_mode,
  input  logic [POS_W-1:0] target_y
`endif
);

  typedef enum logic [1:0] {
    S_STILL = 2'd0,
    S_SLOW  = 2'd1,
    S_FAST  = 2'd2,
    S_BOOST = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    Z_STILL,
    Z_SLOW,
    Z_FAST
  } zone_e;

  localparam int SW  = POS_W + 2;
  localparam int BW  = $clog2(BOOST_FRAMES + 2);
  localparam int SCW = $clog2(STALE_FRAMES + 1);

  localparam logic signed [SW-1:0] Y_MIN_S    = SW'(Y_MIN);
  localparam logic signed [SW-1:0] Y_MAX_S    = SW'(Y_MAX);
  localparam logic signed [SW-1:0] STEP_SLOW  = SW'(SLOW_STEP);
  localparam logic signed [SW-1:0] STEP_FAST  = SW'(FAST_STEP);
  localparam logic signed [SW-1:0] STEP_BOOST = SW'(BOOST_STEP);
  localparam logic [BW-1:0]        BOOST_LIM  = BW'(BOOST_FRAMES);
  localparam logic [BW-1:0]        BOOST_SAT  = BW'(BOOST_FRAMES + 1);
  localparam logic [SCW-1:0]       STALE_MAX  = SCW'(STALE_FRAMES);
  localparam logic [JOY_W-1:0]     JOY_REST   = JOY_W'((int'(DEAD_LO) + int'(DEAD_HI)) / 2);

  logic             eof_q;
  logic [JOY_W-1:0] joy_q;
  logic [SCW-1:0]   stale_cnt_q, stale_cnt_inc;
  logic [POS_W-1:0] y_q, y_d;
  state_e           state_q, state_d;
  logic [BW-1:0]    boost_q, boost_d;
  logic             dir_q, dir_d;
  logic             moving_q, stale_q;

  logic             frame_pulse, stale_hit;
  zone_e            joy_zone, auto_zone, zone;
  logic             joy_neg, auto_neg, move_neg, auto_active;
  logic signed [SW-1:0] y_ext, step, sum;

  assign frame_pulse   = endofframe & ~eof_q;
  assign stale_cnt_inc = (stale_cnt_q == STALE_MAX) ? stale_cnt_q : stale_cnt_q + 1'b1;
  // A fresh sample arriving on the frame edge means the input is not stale this frame.
  assign stale_hit     = ~joy_valid & (stale_cnt_inc == STALE_MAX);
  assign y_ext         = $signed({2'b00, y_q});

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    joy_zone = Z_STILL;
    joy_neg  = 1'b0;
    if (joy_q > FAST_HI) begin
      joy_zone = Z_FAST;
      joy_neg  = 1'b1;
    end else if (joy_q > DEAD_HI) begin
      joy_zone = Z_SLOW;
      joy_neg  = 1'b1;
    end else if (joy_q > DEAD_LO) begin
      joy_zone = Z_STILL;
    end else if (joy_q > FAST_LO) begin
      joy_zone = Z_SLOW;
    end else begin
      joy_zone = Z_FAST;
    end
  end

`ifdef PADDLE_AUTO_EN
  localparam logic signed [SW-1:0] HALF_H   = SW'(PADDLE_H / 2);
  localparam logic [SW-1:0]        DEAD_ABS = SW'(AUTO_DEAD);
  localparam logic [SW-1:0]        FAST_ABS = SW'(AUTO_FAST_DIST);

  logic signed [SW-1:0] dist;
  logic [SW-1:0]        dist_abs;

  // Distance from paddle centre to target; positive means the paddle must move down (y up).
  assign dist        = $signed({2'b00, target_y}) - (y_ext + HALF_H);
  assign dist_abs    = dist[SW-1] ? $unsigned(-dist) : $unsigned(dist);
  assign auto_active = auto_mode;
  assign auto_neg    = dist[SW-1];

  always_comb begin
    if (dist_abs <= DEAD_ABS)      auto_zone = Z_STILL;
    else if (dist_abs <= FAST_ABS) auto_zone = Z_SLOW;
    else                           auto_zone = Z_FAST;
  end
`else
  assign auto_active = 1'b0;
  assign auto_neg    = 1'b0;
  assign auto_zone   = Z_STILL;
`endif

  always_comb begin
    zone     = joy_zone;
    move_neg = joy_neg;
    if (auto_active) begin
      zone     = auto_zone;
      move_neg = auto_neg;
    end else if (stale_hit) begin
      zone = Z_STILL;
    end

    state_d = state_q;
    boost_d = boost_q;
    dir_d   = dir_q;
    case (zone)
      Z_STILL: begin
        state_d = S_STILL;
        boost_d = '0;
      end
      Z_SLOW: begin
        state_d = S_SLOW;
        boost_d = '0;
      end
      default: begin
        if ((state_q == S_FAST || state_q == S_BOOST) && move_neg == dir_q) begin
          if (boost_q != BOOST_SAT) boost_d = boost_q + 1'b1;
          state_d = (boost_d > BOOST_LIM) ? S_BOOST : S_FAST;
        end else begin
          state_d = S_FAST;
          boost_d = BW'(1);
          dir_d   = move_neg;
        end
      end
    endcase

    case (state_d)
      S_SLOW:  step = STEP_SLOW;
      S_FAST:  step = STEP_FAST;
      S_BOOST: step = STEP_BOOST;
      default: step = '0;
    endcase

    // Wide signed sum so a step past either edge saturates instead of wrapping.
    sum = move_neg ? (y_ext - step) : (y_ext + step);
    if (sum < Y_MIN_S)      y_d = POS_W'(Y_MIN);
    else if (sum > Y_MAX_S) y_d = POS_W'(Y_MAX);
    else                    y_d = sum[POS_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      eof_q       <= 1'b1;
      joy_q       <= JOY_REST;
      stale_cnt_q <= '0;
      y_q         <= POS_W'(Y_INIT);
      state_q     <= S_STILL;
      boost_q     <= '0;
      dir_q       <= 1'b0;
      moving_q    <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      eof_q <= endofframe;
      if (joy_valid) joy_q <= joy_y;
      if (joy_valid)        stale_cnt_q <= '0;
      else if (frame_pulse) stale_cnt_q <= stale_cnt_inc;
      if (frame_pulse) begin
        y_q      <= y_d;
        state_q  <= state_d;
        boost_q  <= boost_d;
        dir_q    <= dir_d;
        moving_q <= (zone != Z_STILL);
        stale_q  <= stale_hit;
      end
    end
  end

  assign y           = y_q;
  assign isMoving    = moving_q;
  assign speed_state = state_q;
  assign stale       = stale_q;
  assign at_top      = (y_q == POS_W'(Y_MIN));
  assign at_bot      = (y_q == POS_W'(Y_MAX));

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl: per-frame expectations queued, then compared after each frame edge.
module tb_paddle_motion_ctrl;

  localparam int POS_W = 10;
  localparam int JOY_W = 10;

  logic             clk50M = 1'b0;
  logic             reset;
  logic             endofframe;
  logic [JOY_W-1:0] joy_y;
  logic             joy_valid;
  logic [POS_W-1:0] y;
  logic             isMoving;
  logic [1:0]       speed_state;
  logic             at_top;
  logic             at_bot;
  logic             stale;
`ifdef PADDLE_AUTO_EN
  logic             auto_mode;
  logic [POS_W-1:0] target_y;
`endif

  typedef struct packed {
    logic [POS_W-1:0] y;
    logic [1:0]       spd;
    logic             mv;
    logic             st;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [POS_W-1:0] ey;

  always #10 clk50M = ~clk50M;

  paddle_motion_ctrl dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .endofframe  (endofframe),
    .joy_y       (joy_y),
    .joy_valid   (joy_valid),
    .y           (y),
    .isMoving    (isMoving),
    .speed_state (speed_state),
    .at_top      (at_top),
    .at_bot      (at_bot),
    .stale       (stale)
`ifdef PADDLE_AUTO_EN
    ,
    .auto_mode   (auto_mode),
    .target_y    (target_y)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vmode: 0 = no sample, 1 = sample before the frame edge, 2 = sample on the frame edge.
  task automatic do_frame(input string tag, input logic [JOY_W-1:0] jy, input int vmode,
                          input logic [POS_W-1:0] e_y, input logic [1:0] e_spd,
                          input logic e_mv, input logic e_st);
    exp_t e;
    sb.push_back('{y: e_y, spd: e_spd, mv: e_mv, st: e_st});
    if (vmode == 1) begin
      @(negedge clk50M);
      joy_y     = jy;
      joy_valid = 1'b1;
      @(negedge clk50M);
      joy_valid = 1'b0;
    end
    @(negedge clk50M);
    endofframe = 1'b1;
    if (vmode == 2) begin
      joy_y     = jy;
      joy_valid = 1'b1;
    end
    @(negedge clk50M);
    joy_valid = 1'b0;
    e = sb.pop_front();
    check({tag, "_y"},   y,           e.y);
    check({tag, "_spd"}, speed_state, e.spd);
    check({tag, "_mv"},  isMoving,    e.mv);
    check({tag, "_st"},  stale,       e.st);
    check({tag, "_top"}, at_top,      e.y == 10);
    check({tag, "_bot"}, at_bot,      e.y == 420);
    @(negedge clk50M);
    check({tag, "_hold"}, y, e.y);
    endofframe = 1'b0;
  endtask

  // Reset is raised together with a rising endofframe and a joystick sample; reset must win both.
  task automatic apply_reset();
    @(negedge clk50M);
    reset      = 1'b1;
    endofframe = 1'b1;
    joy_y      = 10'h000;
    joy_valid  = 1'b1;
    @(negedge clk50M);
    joy_valid = 1'b0;
    check("rst_y",   y,           40);
    check("rst_spd", speed_state, 0);
    check("rst_mv",  isMoving,    0);
    check("rst_st",  stale,       0);
    check("rst_top", at_top,      0);
    check("rst_bot", at_bot,      0);
    reset = 1'b0;
    repeat (2) @(negedge clk50M);
    check("rst_eof_y",   y,           40);
    check("rst_eof_spd", speed_state, 0);
    endofframe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    endofframe = 1'b1;
    joy_valid  = 1'b0;
    joy_y      = '0;
`ifdef PADDLE_AUTO_EN
    auto_mode  = 1'b0;
    target_y   = '0;
`endif

    // Reset state, then the rest sample must be still.
    apply_reset();
    do_frame("rest_sample", 10'h000, 0, 40, 0, 0, 0);
    do_frame("first",       10'h200, 1, 40, 0, 0, 0);

    // Slow up, then zone boundaries (equality falls to the lower zone).
    ey = 40;
    for (int i = 0; i < 5; i++) begin
      ey = ey - 1;
      do_frame("slow_neg", 10'h250, 1, ey, 1, 1, 0);
    end
    do_frame("eq_dead_hi", 10'h220, 1, 35, 0, 0, 0);
    do_frame("eq_dead_lo", 10'h180, 1, 36, 1, 1, 0);
    do_frame("eq_fast_hi", 10'h300, 1, 35, 1, 1, 0);
    do_frame("eq_fast_lo", 10'h0F0, 1, 38, 2, 1, 0);

    // Climb to 200, then fast/boost upward and a reversal.
    apply_reset();
    ey = 40;
    for (int i = 0; i < 160; i++) begin
      ey = ey + 1;
      do_frame("climb", 10'h100, 1, ey, 1, 1, 0);
    end
    for (int i = 1; i <= 12; i++) begin
      ey = ey - ((i <= 8) ? 10'd3 : 10'd6);
      do_frame("boost_up", 10'h3FF, 1, ey, (i <= 8) ? 2'd2 : 2'd3, 1, 0);
    end
    do_frame("reverse",  10'h000, 1, 155, 2, 1, 0);
    do_frame("reverse2", 10'h000, 1, 158, 2, 1, 0);

    // Top clamp from y=12.
    apply_reset();
    ey = 40;
    for (int i = 0; i < 28; i++) begin
      ey = ey - 1;
      do_frame("to_top", 10'h250, 1, ey, 1, 1, 0);
    end
    do_frame("clamp_top",  10'h3FF, 1, 10, 2, 1, 0);
    do_frame("clamp_top2", 10'h3FF, 1, 10, 2, 1, 0);

    // Bottom clamp from y=418.
    apply_reset();
    ey = 40;
    for (int i = 0; i < 378; i++) begin
      ey = ey + 1;
      do_frame("to_bot", 10'h100, 1, ey, 1, 1, 0);
    end
    do_frame("clamp_bot",  10'h000, 1, 420, 2, 1, 0);
    do_frame("clamp_bot2", 10'h000, 1, 420, 2, 1, 0);

    // Staleness: one sample, then 30 frames without joy_valid.
    apply_reset();
    ey = 40;
    for (int k = 1; k <= 31; k++) begin
      if (k <= 29) ey = ey + ((k <= 8) ? 10'd3 : 10'd6);
      do_frame("stale_run", 10'h000, (k == 1) ? 1 : 0, ey,
               (k >= 30) ? 2'd0 : ((k <= 8) ? 2'd2 : 2'd3), k < 30, k >= 30);
    end
    do_frame("resume",         10'h000, 1, 193, 2, 1, 0);
    do_frame("coincide",       10'h200, 2, 196, 2, 1, 0);
    do_frame("after_coincide", 10'h200, 0, 196, 0, 0, 0);

`ifdef PADDLE_AUTO_EN
    // Auto tracking from y=100 toward target 200 (centre offset 25, settles at 173).
    apply_reset();
    ey = 40;
    for (int i = 0; i < 60; i++) begin
      ey = ey + 1;
      do_frame("auto_approach", 10'h100, 1, ey, 1, 1, 0);
    end
    auto_mode = 1'b1;
    target_y  = 10'd200;
    for (int k = 1; k <= 31; k++) begin
      if (k <= 8)       ey = ey + 10'd3;
      else if (k <= 14) ey = ey + 10'd6;
      else if (k <= 27) ey = ey + 10'd1;
      do_frame("auto", 10'h000, 0, ey,
               (k <= 8) ? 2'd2 : (k <= 14) ? 2'd3 : (k <= 27) ? 2'd1 : 2'd0,
               k <= 27, k >= 29);
    end
    auto_mode = 1'b0;
`endif

    // Reset in the middle of activity returns to the initial position.
    apply_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
